motor_drive_ctrl: RTL and testbench
===================================

MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

Interface
REQ-001 Parameter PWM_BITS, default 8, SHALL set PWM counter and duty width.
REQ-002 Parameter MAX_DUTY, default 200, SHALL set wheel duty for forward/backward.
REQ-003 Parameter TURN_DUTY, default 120, SHALL set wheel duty for pivot turns.
REQ-004 Parameter RAMP_STEP, default 8, SHALL set duty change per ramp tick.
REQ-005 Parameter RAMP_DIV, default 16, SHALL set clocks per ramp tick.
REQ-006 Parameter DEAD_CYC, default 32, SHALL set dead-time clocks before a direction flip.
REQ-007 clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 motor_fwd, motor_bwd, motor_left, motor_right, motor_stop  in  1 each  level commands from the robot FSM.
REQ-010 pwm_l, pwm_r  out  1 each  left/right wheel PWM.
REQ-011 dir_l, dir_r  out  1 each  wheel direction, 1 = forward.
REQ-012 duty_l, duty_r  out  PWM_BITS each  current ramped duty.
REQ-013 at_speed  out  1  both wheels settled at target.

Function
REQ-014 Decode SHALL give signed targets (L,R): fwd (+MAX,+MAX); bwd (-MAX,-MAX); left (-TURN,+TURN); right (+TURN,-TURN); no command, or more than one of fwd/bwd/left/right high: (0,0).
REQ-015 motor_stop=1 SHALL override all: duty_l/duty_r and PWM shadow duties cleared at next edge, no ramp, dir unchanged, ramp divider cleared, wheels to RUN.
REQ-016 Ramp divider SHALL count 0..RAMP_DIV-1 and emit one tick when at RAMP_DIV-1.
REQ-017 Each wheel SHALL run an FSM with states RUN and DEAD.
REQ-018 RUN, target sign equals dir or target 0: on tick, duty moves toward |target| by RAMP_STEP, saturating at |target| (no overshoot).
REQ-019 RUN, target sign opposite dir, duty>0: on tick, duty decreases by min(RAMP_STEP, duty).
REQ-020 RUN, target sign opposite dir, duty==0: next edge enter DEAD, dead counter loaded DEAD_CYC-1.
REQ-021 DEAD: counter decrements each clock; on reaching 0 with opposite target still present, flip dir and return to RUN; duty stays 0 throughout.
REQ-022 DEAD, target becomes 0 or same sign as dir: return to RUN next edge without flip.
REQ-023 PWM counter SHALL count 0..2^PWM_BITS-2 and wrap (period 2^PWM_BITS-1 clocks, 255 default).
REQ-024 Shadow duty SHALL load from duty_x when counter==0; pwm_x = (counter < shadow), registered.
REQ-025 at_speed SHALL be 1 when both wheels in RUN, duty==|target|, and dir matches target sign (any dir if target 0).
REQ-026 Parameter values SHALL satisfy MAX_DUTY, TURN_DUTY <= 2^PWM_BITS-1 and RAMP_STEP >= 1; no runtime checking.

Reset
REQ-027 rst=1 SHALL at next edge set duty_l=duty_r=0, shadows 0, pwm_l=pwm_r=0, dir_l=dir_r=1, all counters 0, FSMs RUN, at_speed=1 (targets 0 with no command).
REQ-028 rst mid-ramp or mid-DEAD SHALL behave identically to REQ-027.

Verification
REQ-029 Reset, hold motor_fwd=1 -> duties rise 8 per 16 clocks, reach 200 after 25 ticks, dir 1/1, at_speed=1; pwm_x high 200 of every 255 clocks.
REQ-030 At fwd 200, switch to motor_left -> left ramps 200->0 (25 ticks), DEAD 32 clocks, dir_l=0, ramps to 120; right ramps 200->120 (10 ticks), dir_r stays 1.
REQ-031 At fwd 200, pulse motor_stop one clock -> next edge duty_l=duty_r=0, pwm_l=pwm_r=0, dir unchanged; after release, ramp restarts from 0.
REQ-032 fwd->bwd, return to fwd during DEAD -> no dir flip, duties ramp 0->200 forward.
REQ-033 motor_fwd=motor_bwd=1 at duty 200 -> target 0, duties ramp to 0, dir unchanged, at_speed=1 at 0.
REQ-034 rst asserted at duty 96 mid-ramp -> next edge all outputs per REQ-027.

Source files
------------

// File: rtl/motor_drive_ctrl.sv
// Two-wheel motor drive controller: decodes level commands into signed wheel
// targets and ramps each wheel's duty toward its target. A dead-time interval
// separates any change of wheel direction. Each wheel drives a registered PWM.
module motor_drive_ctrl #(
   parameter int PWM_BITS  = 8,
   parameter int MAX_DUTY  = 200,
   parameter int TURN_DUTY = 120,
   parameter int RAMP_STEP = 8,
   parameter int RAMP_DIV  = 16,
   parameter int DEAD_CYC  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                motor_fwd,
   input  logic                motor_bwd,
   input  logic                motor_left,
   input  logic                motor_right,
   input  logic                motor_stop,
   output logic                pwm_l,
   output logic                pwm_r,
   output logic                dir_l,
   output logic                dir_r,
   output logic [PWM_BITS-1:0] duty_l,
   output logic [PWM_BITS-1:0] duty_r,
   output logic                at_speed
);

   localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
   // One spare bit so duty +/- step arithmetic never wraps.
   localparam int EXT_W  = PWM_BITS + 1;

   localparam logic [PWM_BITS-1:0] MAX_D     = PWM_BITS'(MAX_DUTY);
   localparam logic [PWM_BITS-1:0] TURN_D    = PWM_BITS'(TURN_DUTY);
   localparam logic [EXT_W-1:0]    STEP_E    = EXT_W'(RAMP_STEP);
   localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(RAMP_DIV - 1);
   localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);
   // PWM period is 2^PWM_BITS-1 so a full-scale duty gives a constant high.
   localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'((2 ** PWM_BITS) - 2);

   typedef enum logic {ST_RUN, ST_DEAD} state_t;

   // Index 0 is the left wheel, index 1 the right wheel.
   logic [1:0][PWM_BITS-1:0] tgt_mag;
   logic [1:0]               tgt_fwd;
   logic [1:0][PWM_BITS-1:0] duty_v;
   logic [1:0]               dir_v;
   logic [1:0]               pwm_v;
   logic [1:0]               settled_v;

   logic [DIV_W-1:0]    div_q;
   logic                tick;
   logic [PWM_BITS-1:0] cnt_q;

   // Command decode: exactly one motion command selects a target, anything else is zero.
   always_comb begin
      tgt_mag = '0;
      tgt_fwd = 2'b11;
      case ({motor_fwd, motor_bwd, motor_left, motor_right})
         4'b1000: begin tgt_mag = {MAX_D, MAX_D};   tgt_fwd = 2'b11; end
         4'b0100: begin tgt_mag = {MAX_D, MAX_D};   tgt_fwd = 2'b00; end
         4'b0010: begin tgt_mag = {TURN_D, TURN_D}; tgt_fwd = 2'b10; end
         4'b0001: begin tgt_mag = {TURN_D, TURN_D}; tgt_fwd = 2'b01; end
         default: begin tgt_mag = '0;               tgt_fwd = 2'b11; end
      endcase
   end

   assign tick = (div_q == DIV_LAST);

   // Ramp divider; restarted by stop so a fresh ramp begins a full interval later.
   always_ff @(posedge clk) begin
      if (rst || motor_stop) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // Shared PWM period counter, free-running regardless of stop.
   always_ff @(posedge clk) begin
      if (rst || (cnt_q == CNT_LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_wheel
      state_t              state_q, state_d;
      logic [PWM_BITS-1:0] duty_q, duty_d;
      logic                dir_q, dir_d;
      logic [DEAD_W-1:0]   dead_q, dead_d;
      logic [PWM_BITS-1:0] shadow_q, shadow_d;
      logic                pwm_q, pwm_d;
      logic [EXT_W-1:0]    duty_e, mag_e;
      logic                opposite;

      assign duty_e   = EXT_W'(duty_q);
      assign mag_e    = EXT_W'(tgt_mag[gi]);
      assign opposite = (tgt_mag[gi] != '0) && (tgt_fwd[gi] != dir_q);

      // Wheel FSM next state: ramp in RUN, hold zero duty while DEAD times out.
      always_comb begin
         state_d = state_q;
         duty_d  = duty_q;
         dir_d   = dir_q;
         dead_d  = dead_q;
         if (motor_stop) begin
            state_d = ST_RUN;
            duty_d  = '0;
            dead_d  = '0;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (opposite) begin
                     if (duty_q == '0) begin
                        state_d = ST_DEAD;
                        dead_d  = DEAD_LOAD;
                     end else if (tick) begin
                        duty_d = (duty_e > STEP_E) ? PWM_BITS'(duty_e - STEP_E) : '0;
                     end
                  end else if (tick) begin
                     if (duty_e < mag_e) begin
                        duty_d = (duty_e + STEP_E >= mag_e) ? tgt_mag[gi]
                                                            : PWM_BITS'(duty_e + STEP_E);
                     end else if (duty_e > mag_e) begin
                        duty_d = (duty_e >= mag_e + STEP_E) ? PWM_BITS'(duty_e - STEP_E)
                                                            : tgt_mag[gi];
                     end
                  end
               end
               ST_DEAD: begin
                  duty_d = '0;
                  if (!opposite) begin
                     state_d = ST_RUN;
                  end else if (dead_q == '0) begin
                     state_d = ST_RUN;
                     dir_d   = ~dir_q;
                  end else begin
                     dead_d = dead_q - 1'b1;
                  end
               end
               default: state_d = ST_RUN;
            endcase
         end
      end

      // Wheel FSM state register.
      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= ST_RUN;
            duty_q  <= '0;
            dir_q   <= 1'b1;
            dead_q  <= '0;
         end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            dead_q  <= dead_d;
         end
      end

      // Duty is latched at the start of each period so a ramp never splits a pulse.
      always_comb begin
         shadow_d = shadow_q;
         if (motor_stop) begin
            shadow_d = '0;
         end else if (cnt_q == '0) begin
            shadow_d = duty_q;
         end
         pwm_d = (cnt_q < shadow_d);
      end

      // PWM shadow and output registers.
      always_ff @(posedge clk) begin
         if (rst) begin
            shadow_q <= '0;
            pwm_q    <= 1'b0;
         end else begin
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
         end
      end

      assign duty_v[gi]    = duty_q;
      assign dir_v[gi]     = dir_q;
      assign pwm_v[gi]     = pwm_q;
      assign settled_v[gi] = (state_q == ST_RUN) && (duty_q == tgt_mag[gi]) &&
                             ((tgt_mag[gi] == '0) || (dir_q == tgt_fwd[gi]));
   end

   assign duty_l   = duty_v[0];
   assign duty_r   = duty_v[1];
   assign dir_l    = dir_v[0];
   assign dir_r    = dir_v[1];
   assign pwm_l    = pwm_v[0];
   assign pwm_r    = pwm_v[1];
   assign at_speed = &settled_v;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Testbench for motor_drive_ctrl: a table of settled-state vectors checked via
// a scoreboard queue, plus hand-written ramp, dead-time, stop and reset sequences.
module tb_motor_drive_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       motor_fwd, motor_bwd, motor_left, motor_right, motor_stop;
   logic       pwm_l, pwm_r, dir_l, dir_r, at_speed;
   logic [7:0] duty_l, duty_r;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] cmd;     // {fwd, bwd, left, right}
      int         cycles;
      int         dl;
      int         dr;
      logic       dirl;
      logic       dirr;
      logic       spd;
   } vec_t;

   vec_t vecs[9];
   vec_t exp_q[$];

   motor_drive_ctrl dut (
      .clk(clk), .rst(rst),
      .motor_fwd(motor_fwd), .motor_bwd(motor_bwd),
      .motor_left(motor_left), .motor_right(motor_right),
      .motor_stop(motor_stop),
      .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
      .duty_l(duty_l), .duty_r(duty_r), .at_speed(at_speed)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_cmd(input logic [3:0] c);
      {motor_fwd, motor_bwd, motor_left, motor_right} = c;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_state(input string nm, input int dl, input int dr,
                              input logic dirl, input logic dirr, input logic spd);
      $display("%s: duty=%0d/%0d dir=%0b/%0b at_speed=%0b", nm, duty_l, duty_r,
               dir_l, dir_r, at_speed);
      chk({nm, ".duty_l"}, int'(duty_l), dl);
      chk({nm, ".duty_r"}, int'(duty_r), dr);
      chk({nm, ".dir_l"}, int'(dir_l), int'(dirl));
      chk({nm, ".dir_r"}, int'(dir_r), int'(dirr));
      chk({nm, ".at_speed"}, int'(at_speed), int'(spd));
   endtask

   // Apply reset for one edge with no command; called at a negedge.
   task automatic do_reset();
      set_cmd(4'b0000);
      motor_stop = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Bounded wait for duty_l to reach zero; an expired bound is a failed check.
   task automatic wait_duty_l_zero(input string nm);
      int n;
      n = 0;
      while (duty_l != 8'd0 && n < 700) begin
         @(negedge clk);
         n++;
      end
      if (duty_l != 8'd0) chk({nm, ".timeout_duty_l_zero"}, int'(duty_l), 0);
   endtask

   initial begin
      int  highs_l, highs_r, n;
      logic saw_r_bwd, saw_dir_flip, dead_duty_ok;
      vec_t e;

      vecs[0] = '{4'b0000,   2,   0,   0, 1'b1, 1'b1, 1'b1};
      vecs[1] = '{4'b1000, 450, 200, 200, 1'b1, 1'b1, 1'b1};
      vecs[2] = '{4'b0010, 800, 120, 120, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{4'b0001, 800, 120, 120, 1'b1, 1'b0, 1'b1};
      vecs[4] = '{4'b0100, 900, 200, 200, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{4'b1100, 450,   0,   0, 1'b0, 1'b0, 1'b1};
      vecs[6] = '{4'b0011,   5,   0,   0, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{4'b0000,   5,   0,   0, 1'b0, 1'b0, 1'b1};
      vecs[8] = '{4'b1000, 600, 200, 200, 1'b1, 1'b1, 1'b1};

      rst = 1'b1;
      motor_stop = 1'b0;
      set_cmd(4'b0000);
      wait_cycles(3);
      rst = 1'b0;

      // Table pass: push expectation when command is applied, pop when settled.
      for (int i = 0; i < 9; i++) begin
         set_cmd(vecs[i].cmd);
         exp_q.push_back(vecs[i]);
         wait_cycles(vecs[i].cycles);
         e = exp_q.pop_front();
         check_state($sformatf("vec%0d cmd=%b", i, e.cmd), e.dl, e.dr, e.dirl, e.dirr, e.spd);
      end

      // Forward ramp from reset: one step every 16 clocks, 200 after 25 ticks.
      do_reset();
      check_state("reset", 0, 0, 1'b1, 1'b1, 1'b1);
      chk("reset.pwm_l", int'(pwm_l), 0);
      chk("reset.pwm_r", int'(pwm_r), 0);
      set_cmd(4'b1000);
      wait_cycles(15);
      check_state("ramp_pre_tick", 0, 0, 1'b1, 1'b1, 1'b0);
      wait_cycles(1);
      check_state("ramp_first_tick", 8, 8, 1'b1, 1'b1, 1'b0);
      wait_cycles(383);
      check_state("ramp_tick24", 192, 192, 1'b1, 1'b1, 1'b0);
      wait_cycles(1);
      check_state("ramp_tick25", 200, 200, 1'b1, 1'b1, 1'b1);
      wait_cycles(300);
      highs_l = 0;
      highs_r = 0;
      for (int k = 0; k < 255; k++) begin
         @(negedge clk);
         if (pwm_l) highs_l++;
         if (pwm_r) highs_r++;
      end
      $display("pwm window: high_l=%0d high_r=%0d", highs_l, highs_r);
      chk("pwm_l_high_count", highs_l, 200);
      chk("pwm_r_high_count", highs_r, 200);

      // One-clock stop pulse at full speed, then ramp restarts from zero.
      motor_stop = 1'b1;
      @(negedge clk);
      motor_stop = 1'b0;
      check_state("stop", 0, 0, 1'b1, 1'b1, 1'b0);
      chk("stop.pwm_l", int'(pwm_l), 0);
      chk("stop.pwm_r", int'(pwm_r), 0);
      wait_cycles(15);
      check_state("stop_release_pre_tick", 0, 0, 1'b1, 1'b1, 1'b0);
      wait_cycles(1);
      check_state("stop_release_tick", 8, 8, 1'b1, 1'b1, 1'b0);
      wait_cycles(400);
      check_state("refwd", 200, 200, 1'b1, 1'b1, 1'b1);

      // Pivot left: left wheel reverses through dead time, right only slows.
      set_cmd(4'b0010);
      wait_duty_l_zero("left");
      n = 0;
      dead_duty_ok = 1'b1;
      saw_r_bwd = 1'b0;
      while (dir_l != 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
         if (dir_l != 1'b0 && duty_l != 8'd0) dead_duty_ok = 1'b0;
         if (!dir_r) saw_r_bwd = 1'b1;
      end
      $display("left: dir_l flipped %0d clocks after duty_l reached 0", n);
      chk("left.dead_gap", n, 33);
      chk("left.dead_duty_zero", int'(dead_duty_ok), 1);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!dir_r) saw_r_bwd = 1'b1;
      end
      check_state("left_settled", 120, 120, 1'b0, 1'b1, 1'b1);
      chk("left.dir_r_never_flipped", int'(saw_r_bwd), 0);

      // Forward -> backward, return to forward while in dead time: no flip.
      do_reset();
      set_cmd(4'b1000);
      wait_cycles(420);
      check_state("fb_fwd", 200, 200, 1'b1, 1'b1, 1'b1);
      set_cmd(4'b0100);
      wait_duty_l_zero("fb");
      wait_cycles(10);
      check_state("fb_in_dead", 0, 0, 1'b1, 1'b1, 1'b0);
      set_cmd(4'b1000);
      saw_dir_flip = 1'b0;
      for (int k = 0; k < 450; k++) begin
         @(negedge clk);
         if (!dir_l || !dir_r) saw_dir_flip = 1'b1;
      end
      check_state("fb_back_fwd", 200, 200, 1'b1, 1'b1, 1'b1);
      chk("fb.no_dir_flip", int'(saw_dir_flip), 0);

      // Conflicting fwd+bwd decodes to zero target; direction is kept.
      set_cmd(4'b1100);
      wait_cycles(450);
      check_state("conflict", 0, 0, 1'b1, 1'b1, 1'b1);

      // Reset in the middle of a ramp at duty 96.
      do_reset();
      set_cmd(4'b1000);
      wait_cycles(192);
      check_state("mid_ramp", 96, 96, 1'b1, 1'b1, 1'b0);
      do_reset();
      check_state("rst_mid_ramp", 0, 0, 1'b1, 1'b1, 1'b1);
      chk("rst_mid_ramp.pwm_l", int'(pwm_l), 0);
      chk("rst_mid_ramp.pwm_r", int'(pwm_r), 0);

      // Reset during dead time while running backward: dir returns to forward.
      set_cmd(4'b0100);
      wait_cycles(470);
      check_state("bwd", 200, 200, 1'b0, 1'b0, 1'b1);
      set_cmd(4'b1000);
      wait_duty_l_zero("bf");
      wait_cycles(5);
      check_state("bf_in_dead", 0, 0, 1'b0, 1'b0, 1'b0);
      do_reset();
      check_state("rst_mid_dead", 0, 0, 1'b1, 1'b1, 1'b1);
      wait_cycles(40);
      check_state("rst_mid_dead_hold", 0, 0, 1'b1, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
